// File: rtl/githubusername_uart_pkg.sv
// rtl/githubusername_uart_pkg.sv - shared types and constants for the nibble-loaded UART transmitter
package githubusername_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int FRAME_BITS           = 10;
  localparam int DEFAULT_CLKS_PER_BIT = 4;

endpackage

// File: rtl/githubusername_uart_if.sv
// rtl/githubusername_uart_if.sv - packed pin bundle of the UART transmitter
interface githubusername_uart_if;
  // io_i = {send, nib[3:0], nib_wr, rst_n, clk}; io_o = {bit_idx[3:0], overrun, hold_full, busy, tx}
  logic [7:0] io_i;
  logic [7:0] io_o;

  modport master (output io_i, input io_o);
  modport slave  (input io_i, output io_o);
endinterface

// File: rtl/githubusername_uart_tx_core.sv
// rtl/githubusername_uart_tx_core.sv - 8N1 serializer: baud counter, shift register and frame FSM
module uart_tx_core
  import githubusername_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       busy_o,
  output logic [3:0] bit_idx_o
);

  localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [3:0] STOP_IDX  = 4'(FRAME_BITS - 1);

  tx_state_e  state_q, state_d;
  logic [7:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       baud_end;

  assign baud_end = (baud_q == BAUD_LAST);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    tx_o      = 1'b1;
    busy_o    = 1'b1;
    bit_idx_o = 4'd0;
    unique case (state_q)
      ST_IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          state_d = ST_START;
          baud_d  = '0;
          shift_d = data_i;
        end
      end
      ST_START: begin
        tx_o = 1'b0;
        if (baud_end) begin
          state_d = ST_DATA;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + 8'd1;
        end
      end
      ST_DATA: begin
        tx_o      = shift_q[0];
        bit_idx_o = {1'b0, bit_q} + 4'd1;
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = ST_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + 8'd1;
        end
      end
      ST_STOP: begin
        bit_idx_o = STOP_IDX;
        if (baud_end) begin
          state_d = ST_IDLE;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/githubusername_uart_tx.sv
// rtl/githubusername_uart_tx.sv - UART transmitter top: pin mapping, edge detection, nibble holding register
module githubusername_uart_tx
  import githubusername_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  githubusername_uart_if.slave bus
);

  logic       clk, rst_n, nib_wr, send;
  logic [3:0] nib;

  assign clk    = bus.io_i[0];
  assign rst_n  = bus.io_i[1];
  assign nib_wr = bus.io_i[2];
  assign nib    = bus.io_i[6:3];
  assign send   = bus.io_i[7];

  logic       nib_wr_q, send_q;
  logic [7:0] hold_q, hold_d;
  logic [7:0] data_q, data_d;
  logic [1:0] cnt_q, cnt_d;
  logic       overrun_q, overrun_d;
  logic       start_q, start_d;
  logic       nib_edge, send_edge, hold_full, busy_any, accept;
  logic       tx, busy;
  logic [3:0] bit_idx;

  // A pending start counts as busy so a send in that cycle is an overrun, not a second accept
  assign nib_edge  = nib_wr & ~nib_wr_q;
  assign send_edge = send & ~send_q;
  assign hold_full = (cnt_q == 2'd2);
  assign busy_any  = busy | start_q;
  assign accept    = send_edge & ~busy_any & hold_full;

  always_comb begin
    hold_d    = hold_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    overrun_d = overrun_q | (send_edge & busy_any);
    start_d   = accept;
    if (nib_edge) hold_d = {hold_q[3:0], nib};
    if (accept) begin
      data_d = hold_q;
      cnt_d  = nib_edge ? 2'd1 : 2'd0;
    end else if (nib_edge && cnt_q != 2'd2) begin
      cnt_d = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    nib_wr_q <= nib_wr;
    send_q   <= send;
    if (!rst_n) begin
      hold_q    <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      overrun_q <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
      start_q   <= start_d;
    end
  end

  uart_tx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_core (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .start_i   (start_q),
    .data_i    (data_q),
    .tx_o      (tx),
    .busy_o    (busy),
    .bit_idx_o (bit_idx)
  );

  assign bus.io_o = {bit_idx, overrun_q, hold_full, busy, tx};

endmodule

// File: tb/tb_githubusername_uart_tx.sv
// tb/tb_githubusername_uart_tx.sv - self-checking bench for the nibble-loaded UART transmitter
module tb_githubusername_uart_tx;
  import githubusername_uart_pkg::*;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0, rst_n = 1'b0, nib_wr = 1'b0, send = 1'b0;
  logic [3:0] nib = 4'h0;
  int         checks = 0, errors = 0;
  bit         chk_en = 1'b0;

  githubusername_uart_if bus ();
  assign bus.io_i = {send, nib, nib_wr, rst_n, clk};

  githubusername_uart_tx #(.CLKS_PER_BIT(CPB)) dut (.bus(bus));

  always #5 clk = ~clk;

  // Model: holding-register rules plus a frame timeline; outputs follow from the accept edge by arithmetic
  int         m_edge = 0, m_acc = 0, m_cnt = 0;
  bit         m_active = 1'b0, m_ovr = 1'b0;
  logic       m_pw = 1'b0, m_ps = 1'b0;
  logic [7:0] m_hold = 8'h00, m_byte = 8'h00, exp_o = 8'h01;

  always @(posedge clk) begin
    bit we, se, busy_any, acc;
    int k, b;
    logic t, bz;
    m_edge++;
    if (!rst_n) begin
      m_hold = 8'h00; m_cnt = 0; m_ovr = 1'b0; m_active = 1'b0;
    end else begin
      we = nib_wr && !m_pw;
      se = send && !m_ps;
      busy_any = m_active && (m_edge - 1 >= m_acc) && (m_edge - 1 <= m_acc + FRAME);
      acc = se && !busy_any && (m_cnt == 2);
      if (se && busy_any) m_ovr = 1'b1;
      if (acc) begin m_active = 1'b1; m_acc = m_edge; m_byte = m_hold; end
      if (we) m_hold = {m_hold[3:0], nib};
      if (acc) m_cnt = we ? 1 : 0;
      else if (we && m_cnt < 2) m_cnt = m_cnt + 1;
    end
    m_pw = nib_wr;
    m_ps = send;
    b = 0; t = 1'b1; bz = 1'b0;
    if (m_active && m_edge >= m_acc + 1 && m_edge <= m_acc + FRAME) begin
      k = m_edge - m_acc - 1;
      b = k / CPB;
      bz = 1'b1;
      t = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : m_byte[b-1];
    end
    exp_o = {b[3:0], m_ovr, (m_cnt == 2), bz, t};
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (bus.io_o !== exp_o) begin
        errors++;
        $display("FAIL model_cycle edge=%0d got=%h expected=%h", m_edge, bus.io_o, exp_o);
      end
    end
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_nib(input logic [3:0] v);
    nib = v; nib_wr = 1'b1; tick(1);
    nib_wr = 1'b0; tick(1);
  endtask

  // Observer only: waits for busy, samples tx every cycle of the frame, returns in the first idle cycle
  task automatic capture(output logic [7:0] byte_o, output logic [9:0] bits_o,
                         output int lat, output int blen);
    logic [39:0] s;
    int n;
    lat = 0; blen = 0; byte_o = 8'h00; bits_o = 10'h3ff; s = '1;
    do begin @(negedge clk); lat++; end while (!bus.io_o[1] && lat < 10);
    if (!bus.io_o[1]) begin
      checks++; errors++;
      $display("FAIL busy_rise_timeout got=0 expected=1");
      return;
    end
    for (int k = 0; k < FRAME; k++) begin
      s[k] = bus.io_o[0];
      if (bus.io_o[1]) blen++;
      @(negedge clk);
    end
    n = 0;
    while (bus.io_o[1] && n < 20) begin blen++; n++; @(negedge clk); end
    for (int i = 0; i < 10; i++) begin
      bits_o[i] = s[CPB*i];
      for (int j = 1; j < CPB; j++)
        if (s[CPB*i+j] !== bits_o[i]) begin
          checks++; errors++;
          $display("FAIL bit_width bit=%0d got=%b expected=%b", i, s[CPB*i+j], bits_o[i]);
        end
    end
    byte_o = bits_o[8:1];
  endtask

  task automatic send_frame(output logic [7:0] byte_o, output logic [9:0] bits_o,
                            output int lat, output int blen);
    send = 1'b1;
    fork
      capture(byte_o, bits_o, lat, blen);
      begin tick(1); send = 1'b0; nib_wr = 1'b0; end
    join
  endtask

  initial begin
    logic [7:0] by, by2;
    logic [9:0] bits, bits2;
    int lat, blen, lat2, blen2, busy_seen;

    rst_n = 1'b0;
    tick(3);
    chk_en = 1'b1;
    check("reset_state", 16'(bus.io_o), 16'h0001);
    rst_n = 1'b1;
    tick(1);

    write_nib(4'hA);
    check("hold_full_one_nibble", 16'(bus.io_o[2]), 16'h0);
    write_nib(4'h5);
    check("hold_full_two_nibbles", 16'(bus.io_o[2]), 16'h1);
    send_frame(by, bits, lat, blen);
    check("frame_a5_bits", 16'(bits), 16'h034a);
    check("frame_a5_byte", 16'(by), 16'h00a5);
    check("send_to_busy_latency", 16'(lat), 16'd2);
    check("busy_length", 16'(blen), 16'd40);
    check("hold_full_after_accept", 16'(bus.io_o[2]), 16'h0);

    write_nib(4'h7);
    send = 1'b1; tick(1); send = 1'b0; tick(8);
    check("send_one_nibble_ignored", 16'(bus.io_o), 16'h0001);

    write_nib(4'h1); write_nib(4'h2); write_nib(4'h3);
    check("hold_full_saturated", 16'(bus.io_o[2]), 16'h1);
    send_frame(by, bits, lat, blen);
    check("three_nibbles_byte", 16'(by), 16'h0023);

    write_nib(4'h1); write_nib(4'h2);
    nib = 4'h9; nib_wr = 1'b1;
    send_frame(by, bits, lat, blen);
    check("same_cycle_write_byte", 16'(by), 16'h0012);
    check("same_cycle_write_count", 16'(bus.io_o[2]), 16'h0);
    write_nib(4'h4);
    check("same_cycle_write_refill", 16'(bus.io_o[2]), 16'h1);
    send_frame(by, bits, lat, blen);
    check("same_cycle_next_byte", 16'(by), 16'h0094);

    write_nib(4'hA); write_nib(4'h5);
    send = 1'b1;
    fork
      capture(by, bits, lat, blen);
      begin tick(1); send = 1'b0; tick(11); send = 1'b1; tick(2); send = 1'b0; end
    join
    check("overrun_frame_byte", 16'(by), 16'h00a5);
    check("overrun_busy_length", 16'(blen), 16'd40);
    check("overrun_set", 16'(bus.io_o[3]), 16'h1);

    write_nib(4'hA); write_nib(4'h5);
    send = 1'b1;
    fork
      capture(by, bits, lat, blen);
      begin tick(1); send = 1'b0; tick(6); write_nib(4'h3); write_nib(4'hC); end
    join
    send_frame(by2, bits2, lat2, blen2);
    check("double_buffer_first", 16'(by), 16'h00a5);
    check("double_buffer_second", 16'(by2), 16'h003c);
    check("back_to_back_latency", 16'(lat2), 16'd2);
    check("overrun_sticky", 16'(bus.io_o[3]), 16'h1);

    write_nib(4'hA); write_nib(4'h5);
    send = 1'b1;
    tick(15);
    check("midframe_bit_idx", 16'(bus.io_o[7:4]), 16'd3);
    rst_n = 1'b0;
    tick(1);
    check("reset_midframe", 16'(bus.io_o), 16'h0001);
    rst_n = 1'b1;
    busy_seen = 0;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (bus.io_o[1]) busy_seen++;
    end
    check("no_frame_after_reset", 16'(busy_seen), 16'd0);
    check("idle_after_reset", 16'(bus.io_o), 16'h0001);
    send = 1'b0;
    tick(2);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
